npu_result_collector: RTL and testbench

//  Downstream of the NPU/memory top: captures the 8-bit D_OUT result stream, packs bytes

---
 rtl/npu_result_collector_pkg.sv | 37 +++
 rtl/npu_result_collector_if.sv | 24 ++
 rtl/npu_result_collector_result_fifo.sv | 68 ++++++
 rtl/npu_result_collector.sv | 159 +++++++++++++++
 tb/tb_npu_result_collector.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/npu_result_collector_pkg.sv
// Shared types and register map for the NPU result collector.
// Holds the FSM state type, Avalon address decode and STATUS/CTRL bit positions.
package npu_pkg;

  typedef enum logic [1:0] {
    RC_IDLE,
    RC_COLLECT,
    RC_DONE
  } rc_state_t;

  localparam logic [1:0] RC_ADDR_DATA   = 2'd0;
  localparam logic [1:0] RC_ADDR_STATUS = 2'd1;
  localparam logic [1:0] RC_ADDR_CTRL   = 2'd2;

  localparam int unsigned RC_ST_EMPTY = 8;
  localparam int unsigned RC_ST_FULL  = 9;
  localparam int unsigned RC_ST_OVF   = 10;
  localparam int unsigned RC_ST_DONE  = 11;
  localparam int unsigned RC_ST_BCNT  = 16;

  localparam int unsigned RC_CTRL_CLR_ALL = 0;
  localparam int unsigned RC_CTRL_CLR_OVF = 1;

  function automatic logic [31:0] rc_status(logic [7:0] cnt, logic empty, logic full,
                                            logic ovf, logic done, logic [7:0] bcnt);
    logic [31:0] s;
    s                          = '0;
    s[7:0]                     = cnt;
    s[RC_ST_EMPTY]             = empty;
    s[RC_ST_FULL]              = full;
    s[RC_ST_OVF]               = ovf;
    s[RC_ST_DONE]              = done;
    s[RC_ST_BCNT +: 8]         = bcnt;
    return s;
  endfunction

endpackage

// File: rtl/npu_result_collector_if.sv
// Result stream input plus Avalon-MM slave port of the NPU result collector.
// The slave modport is the collector; master is the NPU/host side.
interface npu_result_collector_if;
  logic        start;
  logic        d_valid;
  logic [7:0]  d_out;
  logic        chipselect;
  logic        read;
  logic        write;
  logic [1:0]  address;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output start, d_valid, d_out, chipselect, read, write, address, writedata,
    input  readdata, irq
  );

  modport slave (
    input  start, d_valid, d_out, chipselect, read, write, address, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/npu_result_collector_result_fifo.sv
// Synchronous word FIFO with flush; a push into a full FIFO succeeds only alongside a pop.
// drop_o flags a push that was lost because the FIFO was full.
module result_fifo #(
  parameter int unsigned Depth = 8,
  parameter int unsigned Width = 32,
  parameter int unsigned CntW  = $clog2(Depth) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [Width-1:0] rdata_o,
  output logic [CntW-1:0]  count_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             drop_o
);
  localparam int unsigned AW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o & ~flush_i;
  assign do_push = push_i & (~full_o | do_pop) & ~flush_i;
  assign drop_o  = push_i & ~do_push & ~flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count gates every observable read.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/npu_result_collector.sv
// Packs the NPU D_OUT byte stream little-endian into 32-bit words, buffers them in a FIFO
// and exposes data/status/control on an Avalon-MM slave with a completion interrupt.
module npu_result_collector
  import npu_pkg::*;
#(
  parameter int unsigned N_RESULTS  = 10,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  npu_result_collector_if.slave  bus
);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [7:0]  NRes  = 8'(N_RESULTS);

  rc_state_t   state_q, state_d;
  logic [7:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] pack_q, pack_d;
  logic [1:0]  lane_q, lane_d;
  logic        push_q, push_d;
  logic [31:0] word_q, word_d;
  logic        ovf_q, ovf_d;
  logic        irq_q, irq_d;
  logic [31:0] readdata_q, readdata_d;

  logic [31:0] fifo_rdata;
  logic [CNT_W-1:0] fifo_count;
  logic        fifo_full, fifo_empty, fifo_drop;
  logic        rd_en, wr_ctrl, clear_all, clear_ovf, pop;
  logic [31:0] pack_new;
  logic [7:0]  cnt_next;
  logic        unused_wdata;

  assign rd_en     = bus.chipselect & bus.read;
  assign wr_ctrl   = bus.chipselect & bus.write & (bus.address == RC_ADDR_CTRL);
  assign clear_all = wr_ctrl & bus.writedata[RC_CTRL_CLR_ALL];
  assign clear_ovf = wr_ctrl & bus.writedata[RC_CTRL_CLR_OVF];
  assign pop       = rd_en & (bus.address == RC_ADDR_DATA) & ~fifo_empty;
  assign unused_wdata = ^bus.writedata[31:2];

  result_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (32),
    .CntW  (CNT_W)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (reset),
    .push_i  (push_q),
    .wdata_i (word_q),
    .pop_i   (pop),
    .flush_i (clear_all),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .drop_o  (fifo_drop)
  );

  always_comb begin
    pack_new = pack_q;
    pack_new[{lane_q, 3'b000} +: 8] = bus.d_out;
    cnt_next = byte_cnt_q + 8'd1;
  end

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    pack_d     = pack_q;
    lane_d     = lane_q;
    push_d     = 1'b0;
    word_d     = word_q;
    ovf_d      = ovf_q;

    unique case (state_q)
      RC_IDLE, RC_DONE: begin
        if (bus.start) begin
          state_d    = RC_COLLECT;
          byte_cnt_d = '0;
          pack_d     = '0;
          lane_d     = '0;
        end
      end
      RC_COLLECT: begin
        if (bus.start) begin
          byte_cnt_d = '0;
          pack_d     = '0;
          lane_d     = '0;
        end else if (bus.d_valid) begin
          byte_cnt_d = cnt_next;
          // Completed word is staged in word_q and pushed on the following edge.
          if (lane_q == 2'd3 || cnt_next == NRes) begin
            word_d = pack_new;
            push_d = 1'b1;
            pack_d = '0;
            lane_d = '0;
          end else begin
            pack_d = pack_new;
            lane_d = lane_q + 2'd1;
          end
          if (cnt_next == NRes) state_d = RC_DONE;
        end
      end
      default: state_d = RC_IDLE;
    endcase

    if (clear_ovf) ovf_d = 1'b0;
    if (fifo_drop) ovf_d = 1'b1;

    if (clear_all) begin
      state_d    = RC_IDLE;
      byte_cnt_d = '0;
      pack_d     = '0;
      lane_d     = '0;
      push_d     = 1'b0;
      ovf_d      = 1'b0;
    end
  end

  always_comb begin
    irq_d      = (state_q == RC_DONE) & ~fifo_empty;
    readdata_d = readdata_q;
    if (rd_en) begin
      unique case (bus.address)
        RC_ADDR_DATA:   readdata_d = fifo_empty ? 32'h0 : fifo_rdata;
        RC_ADDR_STATUS: readdata_d = rc_status(8'(fifo_count), fifo_empty, fifo_full, ovf_q,
                                               state_q == RC_DONE, byte_cnt_q);
        default:        readdata_d = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= RC_IDLE;
      byte_cnt_q <= '0;
      pack_q     <= '0;
      lane_q     <= '0;
      push_q     <= 1'b0;
      word_q     <= '0;
      ovf_q      <= 1'b0;
      irq_q      <= 1'b0;
      readdata_q <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      pack_q     <= pack_d;
      lane_q     <= lane_d;
      push_q     <= push_d;
      word_q     <= word_d;
      ovf_q      <= ovf_d;
      irq_q      <= irq_d;
      readdata_q <= readdata_d;
    end
  end

  assign bus.readdata = readdata_q;
  assign bus.irq      = irq_q;

endmodule

// File: tb/tb_npu_result_collector.sv
// Directed bench for npu_result_collector: Avalon reads queue their expected readdata,
// and a monitor compares one cycle after each read strobe.
module tb_npu_result_collector;
  import npu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  npu_result_collector_if bus();

  npu_result_collector #(
    .N_RESULTS  (10),
    .FIFO_DEPTH (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  string       name_q[$];
  logic        rd_pend = 1'b0;

  always @(posedge clk) rd_pend <= bus.chipselect & bus.read;

  always @(negedge clk) begin
    logic [31:0] e;
    string       n;
    if (rd_pend) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_read actual=%h required=no read pending", bus.readdata);
      end else begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        if (bus.readdata !== e) begin
          errors++;
          $display("FAIL %s actual=%h required=%h", n, bus.readdata, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic send_bytes(input logic [7:0] first, input int n);
    for (int k = 0; k < n; k++) begin
      bus.d_valid = 1'b1;
      bus.d_out   = first + 8'(k);
      tick();
    end
    bus.d_valid = 1'b0;
  endtask

  task automatic rd(input logic [1:0] addr, input logic [31:0] exp, input string name);
    exp_q.push_back(exp);
    name_q.push_back(name);
    bus.chipselect = 1'b1;
    bus.read       = 1'b1;
    bus.address    = addr;
    tick();
    bus.chipselect = 1'b0;
    bus.read       = 1'b0;
  endtask

  task automatic wr(input logic [1:0] addr, input logic [31:0] data);
    bus.chipselect = 1'b1;
    bus.write      = 1'b1;
    bus.address    = addr;
    bus.writedata  = data;
    tick();
    bus.chipselect = 1'b0;
    bus.write      = 1'b0;
  endtask

  initial begin
    logic [31:0] ovf_words [8];
    ovf_words = '{32'h23222120, 32'h27262524, 32'h00002928, 32'h2D2C2B2A,
                  32'h31302F2E, 32'h00003332, 32'h37363534, 32'h3B3A3938};

    bus.start = 1'b0; bus.d_valid = 1'b0; bus.d_out = '0;
    bus.chipselect = 1'b0; bus.read = 1'b0; bus.write = 1'b0;
    bus.address = '0; bus.writedata = '0;
    reset = 1'b0;
    tick(); tick();
    chk("reset_readdata", bus.readdata, 32'h0);
    chk("reset_irq", {31'b0, bus.irq}, 32'h0);
    reset = 1'b1;
    tick();
    rd(RC_ADDR_STATUS, 32'h0000_0100, "reset_status");

    // Single inference, three words, irq around the last pop
    do_start();
    send_bytes(8'h01, 9);
    tick();
    chk("irq_before_final_byte", {31'b0, bus.irq}, 32'h0);
    send_bytes(8'h0A, 1);
    tick(); tick();
    chk("irq_after_third_push", {31'b0, bus.irq}, 32'h1);
    rd(RC_ADDR_STATUS, 32'h000A_0803, "t1_status");
    rd(2'd3, 32'h0, "reserved_read");
    rd(RC_ADDR_DATA, 32'h04030201, "t1_word0");
    rd(RC_ADDR_DATA, 32'h08070605, "t1_word1");
    chk("irq_before_final_pop", {31'b0, bus.irq}, 32'h1);
    rd(RC_ADDR_DATA, 32'h00000A09, "t1_word2");
    chk("irq_cycle_of_final_pop", {31'b0, bus.irq}, 32'h1);
    tick();
    chk("irq_after_final_pop", {31'b0, bus.irq}, 32'h0);

    // Empty FIFO data read
    rd(RC_ADDR_DATA, 32'h0, "empty_data");
    rd(RC_ADDR_STATUS, 32'h000A_0900, "empty_status");

    // Overflow: three inferences without draining
    wr(RC_ADDR_CTRL, 32'h1);
    rd(RC_ADDR_STATUS, 32'h0000_0100, "clear_all_status");
    for (int i = 0; i < 3; i++) begin
      do_start();
      send_bytes(8'h20 + 8'(10 * i), 10);
    end
    tick(); tick();
    rd(RC_ADDR_STATUS, 32'h000A_0E08, "ovf_status");
    chk("irq_full", {31'b0, bus.irq}, 32'h1);
    wr(RC_ADDR_CTRL, 32'h2);
    rd(RC_ADDR_STATUS, 32'h000A_0A08, "clear_ovf_status");

    // Full FIFO: pop lands on the same edge as a push
    do_start();
    send_bytes(8'h40, 4);
    rd(RC_ADDR_DATA, ovf_words[0], "full_pushpop_word");
    rd(RC_ADDR_STATUS, 32'h0004_0208, "full_pushpop_status");
    for (int i = 1; i < 8; i++) rd(RC_ADDR_DATA, ovf_words[i], $sformatf("drain_word%0d", i));
    rd(RC_ADDR_DATA, 32'h43424140, "drain_word8");
    rd(RC_ADDR_DATA, 32'h0, "drain_empty");

    // Restart mid-collection
    wr(RC_ADDR_CTRL, 32'h1);
    do_start();
    send_bytes(8'h01, 6);
    do_start();
    send_bytes(8'hAA, 10);
    tick(); tick();
    rd(RC_ADDR_STATUS, 32'h000A_0804, "restart_status");
    rd(RC_ADDR_DATA, 32'h04030201, "restart_kept_word");
    rd(RC_ADDR_DATA, 32'hADACABAA, "restart_word0");
    rd(RC_ADDR_DATA, 32'hB1B0AFAE, "restart_word1");
    rd(RC_ADDR_DATA, 32'h0000B3B2, "restart_word2");
    tick();
    chk("restart_irq_drained", {31'b0, bus.irq}, 32'h0);

    // Asynchronous reset mid-collection
    do_start();
    send_bytes(8'h01, 5);
    tick();
    rd(RC_ADDR_STATUS, 32'h0005_0001, "pre_reset_status");
    tick(); tick();
    #2;
    reset = 1'b0;
    #1;
    chk("async_reset_readdata", bus.readdata, 32'h0);
    chk("async_reset_irq", {31'b0, bus.irq}, 32'h0);
    tick();
    reset = 1'b1;
    tick();
    send_bytes(8'h77, 3);
    rd(RC_ADDR_STATUS, 32'h0000_0100, "post_reset_status");
    rd(RC_ADDR_DATA, 32'h0, "post_reset_data");

    repeat (3) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_reads actual=%0d required=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
